// File: rtl/apb_master.sv
// apb_master: APB initiator that turns a valid/ready command into one
// SETUP/ACCESS transfer and returns a single-cycle response pulse carrying
// the read data and a timeout flag. One transfer is outstanding at a time.
module apb_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    // Wait counter only needs to reach TIMEOUT-1, so it can never wrap.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        wait_cnt_r;
    logic                    psel_r;
    logic                    penable_r;
    logic                    pwrite_r;
    logic [ADDR_WIDTH-1:0]   paddr_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic                    rsp_err_r;

    // Ready is gated by reset so nothing can be accepted while presetn is low.
    assign cmd_ready = (state_r == IDLE) && presetn;

    assign paddr     = paddr_r;
    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = pwrite_r;
    assign pwdata    = pwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Transfer sequencer: state, bus phase outputs and response registers.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_r     <= IDLE;
            wait_cnt_r  <= '0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= '0;
            pwdata_r    <= '0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rsp_valid_r <= 1'b0;
                    if (cmd_valid) begin
                        paddr_r  <= cmd_addr;
                        pwrite_r <= cmd_write;
                        pwdata_r <= cmd_wdata;
                        psel_r   <= 1'b1;
                        penable_r <= 1'b0;
                        state_r  <= SETUP;
                    end else begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                    end
                end
                SETUP: begin
                    wait_cnt_r <= '0;
                    penable_r  <= 1'b1;
                    state_r    <= ACCESS;
                end
                ACCESS: begin
                    // pready wins over the timeout when both occur together.
                    if (pready) begin
                        rsp_rdata_r <= pwrite_r ? {DATA_WIDTH{1'b0}} : prdata;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        state_r     <= RESP;
                    end else if (wait_cnt_r == CNT_LAST) begin
                        rsp_rdata_r <= {DATA_WIDTH{1'b0}};
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        state_r     <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench for apb_master with a configurable APB
// completer (zero-wait, registered-ready RAM, N wait states, never ready).
module tb_apb_master;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    // Completer model state
    logic [31:0] mem [0:1023];
    int          mode;      // 0 zero-wait, 1 registered ready, 2 wait_n waits, 3 never ready
    int          wait_n;
    logic        stray;
    logic        rr_r;
    int          acc_cnt_r;

    int n_checks;
    int n_errors;

    apb_master #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    assign prdata = mem[paddr];
    assign pready = stray
                  | ((mode == 0) ? 1'b1 :
                     (mode == 1) ? rr_r :
                     (mode == 2) ? (acc_cnt_r == wait_n) : 1'b0);

    // Registered-ready completer: ready one cycle after an access phase starts.
    always_ff @(posedge pclk) rr_r <= psel && penable && !rr_r;

    // Counts access-phase cycles of the current transfer.
    always_ff @(posedge pclk) acc_cnt_r <= (psel && penable) ? acc_cnt_r + 1 : 0;

    // RAM write on a completed write access.
    always_ff @(posedge pclk) begin
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one command; returns latency from accept edge and bus phase counts.
    task automatic do_txn(input logic wr, input logic [9:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int psel_n, output int pen_n, output int unstable);
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        check_val("ready_at_issue", 32'(cmd_ready), 32'd1);
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        lat = 0; psel_n = 0; pen_n = 0; unstable = 0; rd = 32'h0; er = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                break;
            end
            if (psel) begin
                psel_n++;
                if (paddr !== a || pwrite !== wr || pwdata !== d) unstable++;
            end
            if (penable) pen_n++;
            @(negedge pclk);
        end
        if (lat == 0) check_val("rsp_wait_bound", 32'd0, 32'd1);
    endtask

    int          lat, psel_n, pen_n, unst;
    logic [31:0] rd;
    logic        er;
    int          acc_idx [$];

    initial begin
        n_checks = 0; n_errors = 0;
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = 10'h0; cmd_wdata = 32'h0;
        mode = 0; wait_n = 0; stray = 1'b0;

        // Reset state
        repeat (3) @(negedge pclk);
        check_val("rst_psel", 32'(psel), 32'd0);
        check_val("rst_penable", 32'(penable), 32'd0);
        check_val("rst_pwrite", 32'(pwrite), 32'd0);
        check_val("rst_paddr", 32'(paddr), 32'd0);
        check_val("rst_pwdata", pwdata, 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        presetn = 1'b1;
        @(negedge pclk);
        check_val("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // Registered-ready RAM: write then read back
        mode = 1;
        do_txn(1'b1, 10'h015, 32'hDEADBEEF, lat, rd, er, psel_n, pen_n, unst);
        check_val("rr_wr_lat", 32'(lat), 32'd4);
        check_val("rr_wr_err", 32'(er), 32'd0);
        check_val("rr_wr_rdata", rd, 32'd0);
        do_txn(1'b0, 10'h015, 32'h0, lat, rd, er, psel_n, pen_n, unst);
        check_val("rr_rd_lat", 32'(lat), 32'd4);
        check_val("rr_rd_data", rd, 32'hDEADBEEF);
        check_val("rr_rd_err", 32'(er), 32'd0);
        check_val("rr_rd_psel_cycles", 32'(psel_n), 32'd3);

        // Zero-wait completer @0x3FF
        mode = 0;
        do_txn(1'b1, 10'h3FF, 32'h12345678, lat, rd, er, psel_n, pen_n, unst);
        check_val("zw_wr_lat", 32'(lat), 32'd3);
        check_val("zw_wr_rdata", rd, 32'd0);
        do_txn(1'b0, 10'h3FF, 32'hCAFE0001, lat, rd, er, psel_n, pen_n, unst);
        check_val("zw_rd_lat", 32'(lat), 32'd3);
        check_val("zw_rd_psel_cycles", 32'(psel_n), 32'd2);
        check_val("zw_rd_pen_cycles", 32'(pen_n), 32'd1);
        check_val("zw_rd_data", rd, 32'h12345678);
        check_val("zw_rd_pwdata_latched", pwdata, 32'hCAFE0001);

        // Five wait states
        mode = 2; wait_n = 5;
        do_txn(1'b1, 10'h2AA, 32'hA5A50F0F, lat, rd, er, psel_n, pen_n, unst);
        check_val("ws_access_cycles", 32'(pen_n), 32'd6);
        check_val("ws_lat", 32'(lat), 32'd8);
        check_val("ws_stable", 32'(unst), 32'd0);
        check_val("ws_err", 32'(er), 32'd0);
        mode = 0;
        do_txn(1'b0, 10'h2AA, 32'h0, lat, rd, er, psel_n, pen_n, unst);
        check_val("ws_readback", rd, 32'hA5A50F0F);

        // Ready on the very last allowed access cycle completes normally
        mode = 2; wait_n = 15;
        do_txn(1'b0, 10'h015, 32'h0, lat, rd, er, psel_n, pen_n, unst);
        check_val("edge_access_cycles", 32'(pen_n), 32'd16);
        check_val("edge_err", 32'(er), 32'd0);
        check_val("edge_data", rd, 32'hDEADBEEF);

        // Timeout
        mode = 3;
        do_txn(1'b0, 10'h015, 32'h0, lat, rd, er, psel_n, pen_n, unst);
        check_val("to_access_cycles", 32'(pen_n), 32'd16);
        check_val("to_lat", 32'(lat), 32'd18);
        check_val("to_err", 32'(er), 32'd1);
        check_val("to_rdata", rd, 32'd0);
        check_val("to_psel_released", 32'(psel), 32'd0);

        // Reset during the third access wait cycle
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h015;
        @(posedge pclk);
        @(negedge pclk);                 // SETUP
        cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);      // third ACCESS wait cycle
        check_val("rsta_in_access", 32'(penable), 32'd1);
        presetn = 1'b0;
        check_val("rsta_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge pclk);
        check_val("rsta_psel", 32'(psel), 32'd0);
        check_val("rsta_penable", 32'(penable), 32'd0);
        presetn = 1'b1;
        #1;
        check_val("rsta_ready_after", 32'(cmd_ready), 32'd1);
        begin
            int rv_seen;
            rv_seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge pclk);
                if (rsp_valid) rv_seen++;
            end
            check_val("rsta_no_rsp", 32'(rv_seen), 32'd0);
        end
        mode = 0;
        do_txn(1'b0, 10'h015, 32'h0, lat, rd, er, psel_n, pen_n, unst);
        check_val("rsta_next_lat", 32'(lat), 32'd3);
        check_val("rsta_next_data", rd, 32'hDEADBEEF);

        // Stray pready in IDLE does nothing
        mode = 3;
        @(negedge pclk);
        @(negedge pclk);
        stray = 1'b1;
        @(negedge pclk);
        stray = 1'b0;
        check_val("stray_psel", 32'(psel), 32'd0);
        check_val("stray_rsp", 32'(rsp_valid), 32'd0);
        @(negedge pclk);
        check_val("stray_rsp2", 32'(rsp_valid), 32'd0);
        check_val("stray_ready", 32'(cmd_ready), 32'd1);

        // cmd_valid held high: accept once every 4 cycles
        mode = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h3FF;
        for (int i = 0; i < 16; i++) begin
            if (cmd_ready) acc_idx.push_back(i);
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        check_val("bb_accept_count", 32'(acc_idx.size()), 32'd4);
        for (int i = 1; i < acc_idx.size(); i++)
            check_val("bb_accept_spacing", 32'(acc_idx[i] - acc_idx[i-1]), 32'd4);

        repeat (4) @(negedge pclk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers, and returns a one-cycle response pulse with read data and an error flag. It is the requester counterpart to the team's APB completers, such as the APB RAM. It sits between a CPU-side or test-sequencer command source and the APB bus. It issues one transfer at a time, supports completer wait states, and aborts any transfer whose completer stalls beyond a programmable timeout.

## Interface
- ADDR_WIDTH, 10, APB address width
- DATA_WIDTH, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles before abort (must be ≥1)

Clocking and reset (already decided): one clock, `pclk`; reset `presetn` is synchronous and active-low.

- pclk  in  1  clock, all logic on rising edge
- presetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and on timeout
- rsp_err  out  1  1 = transfer timed out
- paddr  out  ADDR_WIDTH  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB completer ready

## Operation
- **States:** IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - cmd_ready=1; psel=penable=0.
  - On accept: latch cmd_addr/cmd_write/cmd_wdata into paddr/pwrite/pwdata, then go to SETUP.
- **SETUP**
  - psel=1, penable=0, for exactly one cycle.
  - Clears the wait counter, then goes to ACCESS.
- **ACCESS:** psel=1, penable=1. Evaluated each cycle in priority order:
  - pready=1: capture prdata into rsp_rdata if it is a read (0 if a write); rsp_err=0; go to RESP.
  - pready=0 and wait counter == TIMEOUT-1: rsp_rdata=0, rsp_err=1; go to RESP.
  - Otherwise: increment the wait counter and stay in ACCESS.
- **RESP**
  - rsp_valid=1 for one cycle; psel=penable=0; then go to IDLE.
- **Signal stability**
  - paddr, pwrite and pwdata are registered.
  - They hold constant from SETUP through the last ACCESS cycle.
  - They keep their last values in IDLE/RESP.
  - pwdata carries the latched cmd_wdata even for reads.
- **Ignored inputs**
  - pready and prdata are ignored outside ACCESS. This tolerates registered-ready completers that hold pready one extra cycle.
  - cmd_valid is ignored outside IDLE; cmd_ready=0 there.
- **Wait counter:** width $clog2(TIMEOUT+1); no wrap is possible.
- **Outstanding transfers:** one at a time; no pipelining.

## Timing
- **Reset**
  - At any rising edge with presetn=0: state=IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_err all go to 0.
  - cmd_ready=0 while presetn=0 and 1 from the first cycle after release.
- **Reset mid-transfer**
  - The bus is released next cycle (psel=penable=0).
  - No rsp_valid is produced and the transfer is dropped.
- **Accept at edge E0:**
  - SETUP during cycle E0+1.
  - First ACCESS during cycle E0+2.
  - With pready=1 in the first ACCESS cycle, rsp_valid is high in cycle E0+3 (3-cycle latency).
- **Registered-ready completer** (pready asserted the cycle after psel&&penable):
  - 4-cycle latency.
  - The completer sees a second ACCESS-phase cycle; this is harmless for RAM-like completers.
- **Wait states:** each cycle of pready=0 in ACCESS adds one cycle of latency, up to TIMEOUT ACCESS cycles total.
- **Throughput:** next accept is possible at the edge ending the IDLE cycle after RESP. Minimum command spacing is SETUP+ACCESS+RESP+IDLE = 4 cycles.
- **Simultaneous events:** pready=1 in the same cycle the counter hits TIMEOUT-1 completes normally (rsp_err=0).

## Test plan
- **Write then read, registered-ready RAM completer:**
  - Write 0xDEADBEEF @0x015, then read @0x015.
  - Required: rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 4 cycles after each accept.
- **Zero-wait completer (pready tied 1), read @0x3FF:**
  - psel high 2 cycles, penable high 1 cycle.
  - rsp_valid exactly 3 cycles after accept; rsp_rdata = prdata value.
- **Wait states (TIMEOUT=16):** pready low for 5 ACCESS cycles, then high.
  - ACCESS lasts 6 cycles; paddr/pwdata/pwrite stable throughout.
  - rsp_err=0.
- **Timeout (TIMEOUT=16):** pready tied 0.
  - ACCESS lasts exactly 16 cycles; psel=0 next cycle.
  - rsp_valid=1, rsp_err=1, rsp_rdata=0.
- **Reset in ACCESS:** presetn=0 for one cycle during the 3rd ACCESS wait cycle.
  - psel=penable=0 next cycle; no rsp_valid.
  - cmd_ready=1 after release; next command completes normally.
- **Command and bus filtering:**
  - cmd_valid held high continuously: accepts occur every 4 cycles with zero-wait completer; none accepted in SETUP/ACCESS/RESP.
  - Stray pready=1 pulse in IDLE has no effect.
